hex_monitor_ctrl: RTL and testbench

- Parametrised board-level debug display controller. Replaces the fixed 2-bit display-select mux in the DE top level.
- Selects one of N_CH monitor words and pages through it in windows of N_DIG hex digits.
- Two active-low push buttons drive navigation, with on-chip synchronisation and debouncing. A hold switch snapshots the selected word.
- Feeds the existing 7-segment decoder interface with one nibble per digit.

---
 rtl/hex_monitor_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_hex_monitor_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// hex_monitor_ctrl
//
// Board-level debug display controller.  Picks one of N_CH monitor words and
// shows it N_DIG hex digits at a time.  Two active-low push buttons step
// through windows and channels.  A hold switch freezes the displayed word.
//
// Optional feature macro: HEX_MONITOR_AUTOSCROLL_EN
//   When defined, the window index also advances every SCROLL_CYC cycles
//   while the display is live.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   iRST      in   synchronous active-low reset
//   iKeyWin   in   raw active-low button, next window
//   iKeyCh    in   raw active-low button, next channel
//   iHold     in   raw switch, 1 = freeze displayed word
//   iData     in   channel c at [c*DATA_W +: DATA_W]
//   oDigits   out  digit d nibble at [4d +: 4], d=0 rightmost
//   oBlank    out  1 = digit lies beyond DATA_W in the current window
//   oWin      out  current window index
//   oCh       out  current channel index
//   oHeld     out  snapshot active
// ---------------------------------------------------------------------------
module hex_monitor_ctrl #(
    parameter int DATA_W     = 64,
    parameter int N_CH       = 4,
    parameter int N_DIG      = 6,
    parameter int DEB_CYC    = 250000,
    parameter int SCROLL_CYC = 50000000,
    localparam int WIN_BITS  = 4 * N_DIG,
    localparam int N_WIN     = (DATA_W + WIN_BITS - 1) / WIN_BITS,
    localparam int WIN_W     = (N_WIN > 1) ? $clog2(N_WIN) : 1,
    localparam int CH_W      = $clog2(N_CH)
) (
    input  logic                     CLOCK_50,
    input  logic                     iRST,
    input  logic                     iKeyWin,
    input  logic                     iKeyCh,
    input  logic                     iHold,
    input  logic [N_CH*DATA_W-1:0]   iData,
    output logic [4*N_DIG-1:0]       oDigits,
    output logic [N_DIG-1:0]         oBlank,
    output logic [WIN_W-1:0]         oWin,
    output logic [CH_W-1:0]          oCh,
    output logic                     oHeld
);

    localparam int DEB_W = $clog2(DEB_CYC);
    localparam int PAD_W = N_WIN * WIN_BITS;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(N_WIN - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    typedef enum logic {LIVE, HELD} state_t;

    logic [DATA_W-1:0] ch_words [N_CH];
    logic [1:0]        key_raw;
    logic              win_press;
    logic              ch_press;
    logic              hold_s1;
    logic              hold_s2;
    logic              hold_prev;
    logic              hold_rise;
    logic              hold_fall;
    logic              scroll_tick;
    logic              win_step;
    state_t            state;
    logic [WIN_W-1:0]  win;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   next_ch;
    logic              held;
    logic [DATA_W-1:0] snap;
    logic [DATA_W-1:0] src_word;
    logic [PAD_W-1:0]  padded;
    logic [PAD_W-1:0]  shifted;
    logic [4*N_DIG-1:0] next_digits;
    logic [N_DIG-1:0]  next_blank;
    logic [4*N_DIG-1:0] digits;
    logic [N_DIG-1:0]  blank;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_words[c] = iData[c*DATA_W +: DATA_W];
    end

    // Key 0 is the window button, key 1 the channel button.
    assign key_raw = {iKeyCh, iKeyWin};

    // Per key: 2-FF synchroniser, then a debouncer that only accepts a level
    // after DEB_CYC consecutive differing samples.  Only the debounced
    // 1->0 edge raises the single-cycle press pulse.
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             s1;
        logic             s2;
        logic             deb;
        logic [DEB_W-1:0] cnt;
        logic             press;

        always_ff @(posedge CLOCK_50) begin
            if (!iRST) begin
                s1    <= 1'b1;
                s2    <= 1'b1;
                deb   <= 1'b1;
                cnt   <= '0;
                press <= 1'b0;
            end else begin
                s1    <= key_raw[k];
                s2    <= s1;
                press <= 1'b0;
                if (s2 == deb) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    deb   <= s2;
                    cnt   <= '0;
                    press <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign win_press = g_key[0].press;
    assign ch_press  = g_key[1].press;

    // The hold switch is only synchronised; its edges drive the FSM.
    always_ff @(posedge CLOCK_50) begin
        if (!iRST) begin
            hold_s1   <= 1'b0;
            hold_s2   <= 1'b0;
            hold_prev <= 1'b0;
        end else begin
            hold_s1   <= iHold;
            hold_s2   <= hold_s1;
            hold_prev <= hold_s2;
        end
    end

    assign hold_rise = hold_s2 & ~hold_prev;
    assign hold_fall = ~hold_s2 & hold_prev;

`ifdef HEX_MONITOR_AUTOSCROLL_EN
    localparam int SCROLL_W = $clog2(SCROLL_CYC);
    localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_CYC - 1);

    logic [SCROLL_W-1:0] scroll_cnt;

    assign scroll_tick = (state == LIVE) && (scroll_cnt == SCROLL_LAST);

    // Free-running period counter while live.  Any press restarts the
    // period so the next automatic step comes a full period after it.
    always_ff @(posedge CLOCK_50) begin
        if (!iRST) begin
            scroll_cnt <= '0;
        end else if ((state != LIVE) || hold_rise || ch_press || win_press || scroll_tick) begin
            scroll_cnt <= '0;
        end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
        end
    end
`else
    logic unused_scroll_cfg;

    assign unused_scroll_cfg = (SCROLL_CYC > 0);
    assign scroll_tick       = 1'b0;
`endif

    // A channel press wins over a window step landing in the same cycle.
    assign win_step = ~ch_press & (win_press | scroll_tick);

    always_comb begin
        next_ch = ch;
        if (ch_press) begin
            next_ch = (ch == CH_LAST) ? '0 : ch + 1'b1;
        end
    end

    // Navigation plus the LIVE/HELD FSM.  The snapshot is taken from the
    // channel that will be current after this edge, so a channel change
    // while held recaptures from the new channel.
    always_ff @(posedge CLOCK_50) begin
        if (!iRST) begin
            state <= LIVE;
            win   <= '0;
            ch    <= '0;
            held  <= 1'b0;
            snap  <= '0;
        end else begin
            ch <= next_ch;
            if (ch_press) begin
                win <= '0;
            end else if (win_step) begin
                win <= (win == WIN_LAST) ? '0 : win + 1'b1;
            end
            case (state)
                LIVE: begin
                    if (hold_rise) begin
                        state <= HELD;
                        held  <= 1'b1;
                        snap  <= ch_words[next_ch];
                    end
                end
                HELD: begin
                    if (hold_fall) begin
                        state <= LIVE;
                        held  <= 1'b0;
                    end else if (ch_press) begin
                        snap <= ch_words[next_ch];
                    end
                end
                default: begin
                    state <= LIVE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

    // Window extraction: zero-pad the word to whole windows, then shift the
    // selected window down to the digit positions.
    assign src_word    = (state == HELD) ? snap : ch_words[ch];
    assign padded      = PAD_W'(src_word);
    assign shifted     = padded >> (int'(win) * WIN_BITS);
    assign next_digits = shifted[WIN_BITS-1:0];

    for (genvar d = 0; d < N_DIG; d++) begin : g_blank
        assign next_blank[d] = ((int'(win) * N_DIG + d) * 4) >= DATA_W;
    end

    // Display outputs are registered, one cycle behind window/source changes.
    always_ff @(posedge CLOCK_50) begin
        if (!iRST) begin
            digits <= '0;
            blank  <= '0;
        end else begin
            digits <= next_digits;
            blank  <= next_blank;
        end
    end

    assign oDigits = digits;
    assign oBlank  = blank;
    assign oWin    = win;
    assign oCh     = ch;
    assign oHeld   = held;

endmodule

// File: tb/tb_hex_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_monitor_ctrl
//
// Self-checking bench for hex_monitor_ctrl with DATA_W=64, N_CH=4, N_DIG=6,
// DEB_CYC=4, SCROLL_CYC=20.  Expected output states are queued when the
// stimulus is applied and popped when the outputs are sampled.
// With HEX_MONITOR_AUTOSCROLL_EN defined only the reset and autoscroll
// scenarios run, since automatic scrolling would move the window under the
// other scenarios.
// ---------------------------------------------------------------------------
module tb_hex_monitor_ctrl;

    localparam int DATA_W     = 64;
    localparam int N_CH       = 4;
    localparam int N_DIG      = 6;
    localparam int DEB_CYC    = 4;
    localparam int SCROLL_CYC = 20;

    logic                   CLOCK_50 = 1'b0;
    logic                   iRST;
    logic                   iKeyWin;
    logic                   iKeyCh;
    logic                   iHold;
    logic [N_CH*DATA_W-1:0] iData;
    logic [4*N_DIG-1:0]     oDigits;
    logic [N_DIG-1:0]       oBlank;
    logic [1:0]             oWin;
    logic [1:0]             oCh;
    logic                   oHeld;

    typedef struct {
        string       name;
        logic [34:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_run  = 0;
    int          n_fail = 0;
    logic [63:0] words [4];

    // Clock generation: 10 time-unit period
    always #5 CLOCK_50 = ~CLOCK_50;

    hex_monitor_ctrl #(
        .DATA_W    (DATA_W),
        .N_CH      (N_CH),
        .N_DIG     (N_DIG),
        .DEB_CYC   (DEB_CYC),
        .SCROLL_CYC(SCROLL_CYC)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .iRST    (iRST),
        .iKeyWin (iKeyWin),
        .iKeyCh  (iKeyCh),
        .iHold   (iHold),
        .iData   (iData),
        .oDigits (oDigits),
        .oBlank  (oBlank),
        .oWin    (oWin),
        .oCh     (oCh),
        .oHeld   (oHeld)
    );

    function automatic logic [34:0] pk(logic [1:0] w, logic [1:0] c, logic h,
                                       logic [5:0] b, logic [23:0] d);
        return {w, c, h, b, d};
    endfunction

    // Reference window: digit d of window w is nibble w*6+d, zero above bit 63
    function automatic logic [23:0] win_of(logic [63:0] word, int w);
        logic [71:0] p;
        p = {8'h00, word};
        return 24'(p >> (w * 24));
    endfunction

    // Only window 2 reaches past bit 63 (digits 16 and 17)
    function automatic logic [5:0] blank_of(int w);
        return (w == 2) ? 6'b110000 : 6'b000000;
    endfunction

    function automatic logic [34:0] observed();
        return {oWin, oCh, oHeld, oBlank, oDigits};
    endfunction

    task automatic expect_push(string name, int w, int c, logic h, logic [63:0] word);
        exp_t x;
        x.name = name;
        x.v    = pk(2'(w), 2'(c), h, blank_of(w), win_of(word, w));
        sb.push_back(x);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic apply_data();
        iData = {words[3], words[2], words[1], words[0]};
    endtask

    // One navigation press: keys low for 10 cycles, then released 10 cycles
    task automatic press(logic win_k, logic ch_k);
        if (win_k) iKeyWin = 1'b0;
        if (ch_k)  iKeyCh  = 1'b0;
        tick(10);
        iKeyWin = 1'b1;
        iKeyCh  = 1'b1;
        tick(10);
    endtask

    // Reset state, then the first registered display value
    task automatic test_reset();
        iRST = 1'b0;
        iKeyWin = 1'b1;
        iKeyCh = 1'b1;
        iHold = 1'b0;
        words[0] = 64'h0123_4567_89AB_CDEF;
        words[1] = 64'hFEDC_BA98_7654_3210;
        words[2] = 64'h1111_2222_3333_4444;
        words[3] = 64'hDEAD_BEEF_CAFE_F00D;
        apply_data();
        sb.push_back('{"reset_state", pk(2'd0, 2'd0, 1'b0, 6'd0, 24'd0)});
        tick(3);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        iRST = 1'b1;
        expect_push("after_reset", 0, 0, 1'b0, words[0]);
        tick(1);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
    endtask

    // Three window presses walk 0 -> 1 -> 2 -> 0
    task automatic test_window();
        for (int i = 0; i < 3; i++) begin
            expect_push($sformatf("win_press_%0d", i), (i + 1) % 3, 0, 1'b0, words[0]);
            press(1'b1, 1'b0);
            e = sb.pop_front(); n_run++;
            if (observed() !== e.v) begin n_fail++;
                $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        end
    endtask

    // Short glitch is ignored; a real press lands exactly DEB_CYC+3 edges in
    task automatic test_debounce();
        iKeyWin = 1'b0;
        tick(2);
        iKeyWin = 1'b1;
        expect_push("glitch", 0, 0, 1'b0, words[0]);
        tick(12);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        iKeyWin = 1'b0;
        expect_push("latency_before", 0, 0, 1'b0, words[0]);
        tick(DEB_CYC + 2);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        sb.push_back('{"latency_win", pk(2'd1, 2'd0, 1'b0, 6'd0, 24'hABCDEF)});
        tick(1);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        expect_push("latency_digits", 1, 0, 1'b0, words[0]);
        tick(1);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        tick(2);
        iKeyWin = 1'b1;
        tick(10);
    endtask

    // Channel stepping, wrap, and simultaneous window+channel press
    task automatic test_channel();
        for (int i = 1; i <= 4; i++) begin
            expect_push($sformatf("ch_press_%0d", i), 0, i % 4, 1'b0, words[i % 4]);
            press(1'b0, 1'b1);
            e = sb.pop_front(); n_run++;
            if (observed() !== e.v) begin n_fail++;
                $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        end
        expect_push("both_keys", 0, 1, 1'b0, words[1]);
        press(1'b1, 1'b1);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        for (int i = 2; i <= 4; i++) begin
            expect_push($sformatf("ch_return_%0d", i), 0, i % 4, 1'b0, words[i % 4]);
            press(1'b0, 1'b1);
            e = sb.pop_front(); n_run++;
            if (observed() !== e.v) begin n_fail++;
                $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        end
    endtask

    // Snapshot freeze, release, recapture on channel change, paging while held
    task automatic test_hold();
        logic [63:0] old_w1;
        words[0] = 64'hAAAA;
        apply_data();
        expect_push("live_aaaa", 0, 0, 1'b0, 64'hAAAA);
        tick(2);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        iHold = 1'b1;
        expect_push("held_enter", 0, 0, 1'b1, 64'hAAAA);
        tick(6);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        words[0] = 64'h5555;
        apply_data();
        expect_push("held_frozen", 0, 0, 1'b1, 64'hAAAA);
        tick(4);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        iHold = 1'b0;
        expect_push("release_live", 0, 0, 1'b0, 64'h5555);
        tick(4);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        iHold = 1'b1;
        tick(6);
        expect_push("held_ch_recapture", 0, 1, 1'b1, words[1]);
        press(1'b0, 1'b1);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        expect_push("held_win_page", 1, 1, 1'b1, words[1]);
        press(1'b1, 1'b0);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        old_w1 = words[1];
        expect_push("held_ignores_live", 1, 1, 1'b1, old_w1);
        words[1] = 64'h0;
        apply_data();
        tick(3);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        iHold = 1'b0;
        expect_push("release_to_zero", 1, 1, 1'b0, 64'h0);
        tick(6);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
    endtask

    // A reset in the middle of debouncing throws the press away
    task automatic test_reset_discard();
        iKeyWin = 1'b0;
        tick(4);
        iRST = 1'b0;
        tick(1);
        iRST = 1'b1;
        iKeyWin = 1'b1;
        expect_push("reset_discard", 0, 0, 1'b0, words[0]);
        tick(15);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
    endtask

`ifdef HEX_MONITOR_AUTOSCROLL_EN
    // Automatic window advance, restart on press, and stop while held
    task automatic test_autoscroll();
        iRST = 1'b0;
        words[0] = 64'h0123_4567_89AB_CDEF;
        apply_data();
        tick(2);
        iRST = 1'b1;
        expect_push("scroll_idle_19", 0, 0, 1'b0, words[0]);
        tick(19);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        sb.push_back('{"scroll_20", pk(2'd1, 2'd0, 1'b0, 6'd0, 24'hABCDEF)});
        tick(1);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        sb.push_back('{"scroll_40", pk(2'd2, 2'd0, 1'b0, 6'd0, 24'h456789)});
        tick(20);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        sb.push_back('{"scroll_60", pk(2'd0, 2'd0, 1'b0, 6'b110000, 24'h000123)});
        tick(20);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        tick(3);
        iKeyWin = 1'b0;
        sb.push_back('{"scroll_press", pk(2'd1, 2'd0, 1'b0, 6'd0, 24'hABCDEF)});
        tick(DEB_CYC + 3);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        tick(2);
        iKeyWin = 1'b1;
        expect_push("scroll_restart_19", 1, 0, 1'b0, words[0]);
        tick(17);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        sb.push_back('{"scroll_restart_20", pk(2'd2, 2'd0, 1'b0, 6'd0, 24'h456789)});
        tick(1);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
        iHold = 1'b1;
        expect_push("scroll_held_stop", 2, 0, 1'b1, words[0]);
        tick(50);
        e = sb.pop_front(); n_run++;
        if (observed() !== e.v) begin n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", e.name, observed(), e.v); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef HEX_MONITOR_AUTOSCROLL_EN
        test_window();
        test_debounce();
        test_channel();
        test_hold();
        test_reset_discard();
`else
        test_autoscroll();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
